serial_control: RTL and testbench

- Control FSM that sequences the 8-bit serial datapath: register loads, then exactly N_SHIFTS shift cycles per Execute press.
- Owns the shift-cycle counter and generates the datapath enables.
- Sits between the debounced board switches/buttons and the register/adder datapath.
- Guarantees exactly one operation per Execute press, however long the button is held.

---
 rtl/serial_control_pkg.sv | 12 +
 rtl/serial_control_shift_counter.sv | 29 ++
 rtl/serial_control.sv | 94 +++++++++
 tb/tb_serial_control.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_control_pkg.sv
// Shared types and constants for the serial_control FSM and its shift counter.
package serial_control_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } ctrl_state_t;

  localparam int DEFAULT_N_SHIFTS = 8;

endpackage

// File: rtl/serial_control_shift_counter.sv
// Shift-cycle counter: steps 0..N_SHIFTS-1 while enabled, pulses wrap on the last step.
module shift_counter
  import serial_control_pkg::*;
#(
  parameter  int N_SHIFTS = DEFAULT_N_SHIFTS,
  localparam int CNT_W    = $clog2(N_SHIFTS)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             enable,
  output logic             wrap,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SHIFTS - 1);

  assign wrap = enable && (count == LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_control.sv
// Control FSM for the 8-bit serial datapath: loads in IDLE, N_SHIFTS shifts per Execute press.
// Optional: define SERIAL_CONTROL_EXEC_SYNC_EN to pass Execute through a 2-flop synchronizer.
module serial_control
  import serial_control_pkg::*;
#(
  parameter  int N_SHIFTS = DEFAULT_N_SHIFTS,
  localparam int CNT_W    = $clog2(N_SHIFTS)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Execute,
  input  logic             LoadA,
  input  logic             LoadB,
  output logic             Ld_A,
  output logic             Ld_B,
  output logic             Shift_En,
  output logic             Done,
  output logic [CNT_W-1:0] Count
);

  ctrl_state_t state_reg;
  ctrl_state_t state_next;
  logic        exec_fsm;
  logic        wrap;

`ifdef SERIAL_CONTROL_EXEC_SYNC_EN
  logic [1:0] exec_sync_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      exec_sync_reg <= '0;
    end else begin
      exec_sync_reg <= {exec_sync_reg[0], Execute};
    end
  end

  assign exec_fsm = exec_sync_reg[1];
`else
  assign exec_fsm = Execute;
`endif

  shift_counter #(
    .N_SHIFTS(N_SHIFTS)
  ) u_shift_counter (
    .Clk   (Clk),
    .Reset (Reset),
    .enable(state_reg == SHIFT),
    .wrap  (wrap),
    .count (Count)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Load enables are combinational from the switches, so they are gated by Reset
  // to stay low while the FSM is held in IDLE by reset.
  always_comb begin
    state_next = state_reg;
    Ld_A       = 1'b0;
    Ld_B       = 1'b0;
    Shift_En   = 1'b0;
    Done       = 1'b0;
    case (state_reg)
      IDLE: begin
        Ld_A = LoadA & ~exec_fsm & ~Reset;
        Ld_B = LoadB & ~exec_fsm & ~Reset;
        if (exec_fsm) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        Shift_En = 1'b1;
        if (wrap) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        Done = 1'b1;
        if (!exec_fsm) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_control.sv
// Self-checking bench for serial_control: behavioural model plus directed and random stimulus.
module tb_serial_control;
  import serial_control_pkg::*;

  localparam int N  = DEFAULT_N_SHIFTS;
  localparam int CW = $clog2(N);
`ifdef SERIAL_CONTROL_EXEC_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic          Clk     = 1'b0;
  logic          Reset   = 1'b1;
  logic          Execute = 1'b0;
  logic          LoadA   = 1'b0;
  logic          LoadB   = 1'b0;
  logic          Ld_A, Ld_B, Shift_En, Done;
  logic [CW-1:0] Count;

  int n_checks = 0;
  int n_fail   = 0;

  serial_control #(
    .N_SHIFTS(N)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Execute (Execute),
    .LoadA   (LoadA),
    .LoadB   (LoadB),
    .Ld_A    (Ld_A),
    .Ld_B    (Ld_B),
    .Shift_En(Shift_En),
    .Done    (Done),
    .Count   (Count)
  );

  always #5 Clk = ~Clk;

  // Reference model: an operation is "shifts still owed" plus a "done, waiting for release" flag.
  int     remaining = 0;
  bit     done_m    = 1'b0;
  bit [1:0] exec_pipe = 2'b00;
  bit     e_now;

  function automatic bit exec_eff();
    return (SYNC_LAT == 0) ? Execute : exec_pipe[1];
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      remaining = 0;
      done_m    = 1'b0;
      exec_pipe = 2'b00;
    end else begin
      e_now = exec_eff();
      if (remaining > 0) begin
        remaining = remaining - 1;
        if (remaining == 0) done_m = 1'b1;
      end else if (done_m) begin
        if (!e_now) done_m = 1'b0;
      end else if (e_now) begin
        remaining = N;
      end
      exec_pipe = {exec_pipe[0], Execute};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit busy;
    bit idle;
    int exp_count;
    busy      = (remaining > 0);
    idle      = !busy && !done_m;
    exp_count = busy ? (N - remaining) : 0;
    chk({tag, ".shift_en"}, 32'(Shift_En), 32'(busy));
    chk({tag, ".done"},     32'(Done),     32'(done_m));
    chk({tag, ".count"},    32'(Count),    32'(exp_count));
    chk({tag, ".ld_a"},     32'(Ld_A),     32'(!Reset && idle && LoadA && !exec_eff()));
    chk({tag, ".ld_b"},     32'(Ld_B),     32'(!Reset && idle && LoadB && !exec_eff()));
  endtask

  always @(negedge Clk) check_all("cycle");

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  // One Execute press held for hold cycles; observes the resulting operation.
  task automatic press(input int hold, input bit with_loada, input string name);
    int shifts, first_shift, first_done, last_done, last_count, total;
    shifts = 0; first_shift = -1; first_done = -1; last_done = -1; last_count = -1;
    total  = hold + N + SYNC_LAT + 8;
    Execute = 1'b1;
    LoadA   = with_loada;
    if (with_loada) begin
      #1;
      chk({name, ".ld_a_suppressed"}, 32'(Ld_A), 32'((SYNC_LAT == 0) ? 0 : 1));
    end
    for (int cyc = 1; cyc <= total; cyc++) begin
      @(negedge Clk);
      if (Shift_En) begin
        shifts++;
        last_count = int'(Count);
        if (first_shift < 0) first_shift = cyc;
      end
      if (Done) begin
        last_done = cyc;
        if (first_done < 0) first_done = cyc;
      end
      if (with_loada && (Shift_En || Done)) chk({name, ".ld_a_busy"}, 32'(Ld_A), 32'(0));
      if (cyc == hold) begin
        #1;
        Execute = 1'b0;
      end
    end
    LoadA = 1'b0;
    chk({name, ".shifts"},      32'(shifts),      32'(N));
    chk({name, ".first_shift"}, 32'(first_shift), 32'(1 + SYNC_LAT));
    chk({name, ".first_done"},  32'(first_done),  32'(N + 1 + SYNC_LAT));
    chk({name, ".last_done"},   32'(last_done),
        32'(((hold > N + 1) ? hold : N + 1) + SYNC_LAT));
    chk({name, ".last_count"},  32'(last_count),  32'(N - 1));
    $display("press %s hold=%0d: shifts=%0d first_shift=%0d done=%0d..%0d",
             name, hold, shifts, first_shift, first_done, last_done);
    step();
  endtask

  initial begin
    int guard;
    int seen;
    // Reset state, sampled while Reset is still asserted.
    #1;
    check_all("reset_init");
    chk("reset_init.count_lit", 32'(Count), 32'(0));
    step();
    step();
    Reset = 1'b0;
    step();

    // Single-cycle loads in IDLE.
    LoadA = 1'b1;
    #1;
    chk("load_a.ld_a", 32'(Ld_A), 32'(1));
    chk("load_a.ld_b", 32'(Ld_B), 32'(0));
    step();
    LoadA = 1'b0;
    LoadB = 1'b1;
    #1;
    chk("load_b.ld_b", 32'(Ld_B), 32'(1));
    chk("load_b.ld_a", 32'(Ld_A), 32'(0));
    step();
    LoadB = 1'b0;
    $display("loads: Ld_A then Ld_B pulses issued");
    step();

    press(20, 1'b0, "held20");
    press(1,  1'b0, "pulse1");
    press(3,  1'b0, "pulse3");
    press(N + 4, 1'b1, "exec_with_loada");

    // Asynchronous reset mid-operation at Count == 3.
    Execute = 1'b1;
    guard = 0;
    while (!(Shift_En && Count == CW'(3)) && guard < 40) begin
      @(negedge Clk);
      guard++;
    end
    chk("reset_mid.reached_count3", 32'(guard < 40), 32'(1));
    #1;
    Reset   = 1'b1;
    Execute = 1'b0;
    #1;
    check_all("reset_mid");
    chk("reset_mid.shift_en_lit", 32'(Shift_En), 32'(0));
    chk("reset_mid.count_lit",    32'(Count),    32'(0));
    chk("reset_mid.done_lit",     32'(Done),     32'(0));
    step();
    Reset = 1'b0;
    seen = 0;
    for (int i = 0; i < N + 6; i++) begin
      @(negedge Clk);
      if (Shift_En) seen++;
    end
    chk("reset_mid.no_more_shifts", 32'(seen), 32'(0));
    $display("reset mid-shift: shifts after reset=%0d", seen);
    step();

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) Execute = ~Execute;
      LoadA = ($urandom_range(0, 3) == 0);
      LoadB = ($urandom_range(0, 3) == 0);
      if (Reset) begin
        Reset = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        Reset = 1'b1;
        #1;
        check_all("rand_reset");
      end
      step();
    end
    Reset = 1'b0;
    Execute = 1'b0;
    LoadA = 1'b0;
    LoadB = 1'b0;
    step();
    $display("random: 3000 cycles of mixed stimulus applied");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
